// File: rtl/serial_udiv.sv
// rtl/serial_udiv.sv - unsigned restoring radix-2 serial divider, one quotient bit per cycle
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   s_axis_dividend_t*          dividend channel (tdata/tvalid/tready)
//   s_axis_divisor_t*           divisor channel (tdata/tvalid/tready)
//   m_axis_dout_tdata           {quotient, remainder}, held until the next result
//   m_axis_dout_tvalid          one-cycle result pulse, cannot be stalled
module serial_udiv #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   s_axis_dividend_tdata,
    input  logic            s_axis_dividend_tvalid,
    output logic            s_axis_dividend_tready,
    input  logic [DW-1:0]   s_axis_divisor_tdata,
    input  logic            s_axis_divisor_tvalid,
    output logic            s_axis_divisor_tready,
    output logic [2*DW-1:0] m_axis_dout_tdata,
    output logic            m_axis_dout_tvalid
);

    localparam int IW = $clog2(DW);
    localparam logic [IW-1:0] LAST_ITER = IW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic            dvd_held;
    logic            dvs_held;
    logic [DW-1:0]   dvd_q;
    logic [DW-1:0]   dvs_q;
    logic [DW-1:0]   quo_q;
    logic [DW-1:0]   rem_q;
    logic [IW-1:0]   iter_q;

    logic            dvd_fire;
    logic            dvs_fire;
    logic [DW:0]     rem_shift;
    logic [DW+1:0]   trial;
    logic            q_bit;
    logic [DW-1:0]   rem_next;
    logic [DW-1:0]   quo_next;

    // Ready is a pure function of registered state, never of tvalid.
    assign s_axis_dividend_tready = (state == IDLE) && !dvd_held;
    assign s_axis_divisor_tready  = (state == IDLE) && !dvs_held;
    assign dvd_fire = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign dvs_fire = s_axis_divisor_tvalid && s_axis_divisor_tready;

    // quo_q starts as the dividend; its MSB is the next dividend bit to bring
    // down, and quotient bits fill in from the LSB as dividend bits leave.
    always_comb begin
        rem_shift = {rem_q, quo_q[DW-1]};
        trial     = {1'b0, rem_shift} - {2'b00, dvs_q};
        q_bit     = ~trial[DW+1];
        // Either branch is below the divisor (or below 2^DW when dividing by
        // zero), so the low DW bits hold the whole remainder.
        rem_next  = q_bit ? trial[DW-1:0] : rem_shift[DW-1:0];
        quo_next  = {quo_q[DW-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            dvd_held           <= 1'b0;
            dvs_held           <= 1'b0;
            dvd_q              <= '0;
            dvs_q              <= '0;
            quo_q              <= '0;
            rem_q              <= '0;
            iter_q             <= '0;
            m_axis_dout_tdata  <= '0;
            m_axis_dout_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    m_axis_dout_tvalid <= 1'b0;
                    if (dvd_fire) begin
                        dvd_q    <= s_axis_dividend_tdata;
                        dvd_held <= 1'b1;
                    end
                    if (dvs_fire) begin
                        dvs_q    <= s_axis_divisor_tdata;
                        dvs_held <= 1'b1;
                    end
                    // Start as soon as both operands are in, counting
                    // captures landing on this very edge.
                    if ((dvd_held || dvd_fire) && (dvs_held || dvs_fire)) begin
                        state  <= BUSY;
                        iter_q <= '0;
                        rem_q  <= '0;
                        quo_q  <= dvd_fire ? s_axis_dividend_tdata : dvd_q;
                    end
                end
                BUSY: begin
                    quo_q  <= quo_next;
                    rem_q  <= rem_next;
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == LAST_ITER) begin
                        state              <= DONE;
                        m_axis_dout_tdata  <= {quo_next, rem_next};
                        m_axis_dout_tvalid <= 1'b1;
                    end
                end
                DONE: begin
                    state              <= IDLE;
                    dvd_held           <= 1'b0;
                    dvs_held           <= 1'b0;
                    m_axis_dout_tvalid <= 1'b0;
                end
                default: begin
                    state              <= IDLE;
                    dvd_held           <= 1'b0;
                    dvs_held           <= 1'b0;
                    m_axis_dout_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_udiv.sv
// tb/tb_serial_udiv.sv - randomized self-checking bench for serial_udiv
module tb_serial_udiv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dvd_data = '0;
    logic        dvd_valid = 1'b0;
    logic        dvd_ready;
    logic [31:0] dvs_data = '0;
    logic        dvs_valid = 1'b0;
    logic        dvs_ready;
    logic [63:0] dout_data;
    logic        dout_valid;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulses = 0;

    serial_udiv #(.DW(32)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready),
        .m_axis_dout_tdata      (dout_data),
        .m_axis_dout_tvalid     (dout_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dout_valid) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return {32'hFFFF_FFFF, a};
        return {a / b, a % b};
    endfunction

    // Offer dividend after da idle cycles and divisor after db, then expect
    // the result exactly 33 cycles after the later handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int da, input int db, input string tag);
        int t = 0;
        int last = -1;
        int n = 0;
        bit ha = 0;
        bit hb = 0;
        logic [63:0] exp;
        exp = ref_div(a, b);
        while (!(ha && hb) && t < 50) begin
            if (ha) check({tag, "_dvd_rdy_low"}, 64'(dvd_ready), 64'd0);
            if (hb) check({tag, "_dvs_rdy_low"}, 64'(dvs_ready), 64'd0);
            dvd_valid = !ha && (t >= da);
            dvd_data  = dvd_valid ? a : $urandom;
            dvs_valid = !hb && (t >= db);
            dvs_data  = dvs_valid ? b : $urandom;
            if (dvd_valid && dvd_ready) begin ha = 1; last = cyc; end
            if (dvs_valid && dvs_ready) begin hb = 1; last = cyc; end
            @(negedge clk);
            t++;
        end
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        dvd_data  = $urandom;
        dvs_data  = $urandom;
        while (!dout_valid && n < 45) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, 64'(dout_valid), 64'd1);
        check({tag, "_lat"}, 64'(cyc - last), 64'd33);
        check({tag, "_data"}, dout_data, exp);
        @(negedge clk);
        check({tag, "_one_pulse"}, 64'(dout_valid), 64'd0);
        check({tag, "_rdy_back"}, {62'd0, dvd_ready, dvs_ready}, 64'd3);
        check({tag, "_data_hold"}, dout_data, exp);
    endtask

    initial begin
        int hs;
        int t1;
        int h2;
        int n;
        int p0;
        bit stable;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] first;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tvalid", 64'(dout_valid), 64'd0);
        check("rst_tdata", dout_data, 64'd0);
        check("rst_ready", {62'd0, dvd_ready, dvs_ready}, 64'd3);

        run_op(32'd100, 32'd7, 0, 0, "basic");
        run_op(32'hFFFF_FFFF, 32'd1, 0, 3, "stagger");
        run_op(32'h1234_5678, 32'd0, 0, 0, "divzero");
        run_op(32'd5, 32'd9, 1, 0, "small");
        run_op(32'h8000_0000, 32'h8000_0000, 0, 2, "msb");

        // Reset on BUSY iteration 10 (cycle N+11).
        dvd_valid = 1'b1; dvd_data = 32'd200;
        dvs_valid = 1'b1; dvs_data = 32'd3;
        hs = cyc;
        @(negedge clk);
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        while (cyc < hs + 11) @(negedge clk);
        reset = 1'b1;
        p0 = pulses;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_ready", {62'd0, dvd_ready, dvs_ready}, 64'd3);
        repeat (40) @(negedge clk);
        check("midrst_no_pulse", 64'(pulses), 64'(p0));
        run_op(32'd50, 32'd5, 0, 0, "after_rst");

        // Back-to-back with valids held high throughout.
        dvd_valid = 1'b1; dvd_data = 32'd1000;
        dvs_valid = 1'b1; dvs_data = 32'd33;
        hs = cyc;
        @(negedge clk);
        dvd_data = 32'hDEAD_BEEF;
        dvs_data = 32'd17;
        n = 0;
        while (!dout_valid && n < 45) begin @(negedge clk); n++; end
        t1 = cyc;
        first = dout_data;
        check("b2b_lat1", 64'(t1 - hs), 64'd33);
        check("b2b_data1", first, ref_div(32'd1000, 32'd33));
        @(negedge clk);
        h2 = -1;
        stable = 1;
        n = 0;
        while (!dout_valid && n < 45) begin
            if (dout_data !== first) stable = 0;
            if (h2 < 0 && dvd_ready && dvs_ready) h2 = cyc;
            @(negedge clk);
            n++;
        end
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        check("b2b_hs2", 64'(h2 - t1), 64'd1);
        check("b2b_hold", 64'(stable), 64'd1);
        check("b2b_gap", 64'(cyc - t1), 64'd34);
        check("b2b_data2", dout_data, ref_div(32'hDEAD_BEEF, 32'd17));
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 255));
                2: rb = $urandom;
                default: rb = ra >> $urandom_range(0, 31);
            endcase
            run_op(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_udiv.md
SERIAL_UDIV -- requirements
Module: serial_udiv

Interface
REQ-001 SHALL take parameter DW, default 32, operand width; only 32 is required to be supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port s_axis_dividend_tdata, input, 32, the unsigned dividend.
REQ-005 SHALL have port s_axis_dividend_tvalid, input, 1, the dividend offer.
REQ-006 SHALL have port s_axis_dividend_tready, output, 1, the dividend accept.
REQ-007 SHALL have port s_axis_divisor_tdata, input, 32, the unsigned divisor.
REQ-008 SHALL have port s_axis_divisor_tvalid, input, 1, the divisor offer.
REQ-009 SHALL have port s_axis_divisor_tready, output, 1, the divisor accept.
REQ-010 SHALL have port m_axis_dout_tdata, output, 64, {quotient[63:32], remainder[31:0]}.
REQ-011 SHALL have port m_axis_dout_tvalid, output, 1, the result-valid pulse; there is no tready, so the consumer cannot stall it.

Function
REQ-012 SHALL implement the states IDLE, BUSY and DONE, plus one held-flag per operand channel.
- REQ-012a In IDLE, the flags record which operands have been captured.
REQ-013 SHALL capture each operand channel independently on the cycle tvalid&&tready is high, then set that channel's held-flag.
REQ-014 SHALL drive each channel's tready as (state==IDLE) && !held_flag; tready depends on no input combinationally.
REQ-015 SHALL leave IDLE for BUSY on the edge where both held-flags are set.
- REQ-015a Both held-flags are set either by earlier captures or by captures in the current cycle, including both channels in the same cycle.
REQ-016 SHALL perform a restoring radix-2 division in BUSY at one quotient bit per cycle, MSB first.
- REQ-016a Each step uses a 33-bit partial remainder: shift left, bring in the next dividend bit, trial-subtract the divisor, keep the result when it is non-negative, and set the quotient bit to the inverted borrow.
REQ-017 SHALL use an iteration counter running 0..31 and enter DONE after exactly 32 BUSY cycles.
REQ-018 SHALL assert m_axis_dout_tvalid for exactly one cycle, in DONE, then return to IDLE with both held-flags cleared.
REQ-019 SHALL fix the latency as follows: if the last operand handshake occurs in cycle N, m_axis_dout_tvalid is high in cycle N+33.
REQ-020 SHALL hold m_axis_dout_tdata stable from the DONE cycle until the next DONE, so the consumer may sample it late.
REQ-021 SHALL produce quotient 0xFFFFFFFF and remainder equal to the dividend on divide-by-zero, with no error flag and no change in latency.
REQ-022 SHALL produce correct results at the boundary cases: dividend < divisor gives {0, dividend}, and divisor 1 gives {dividend, 0}.
REQ-023 SHALL ignore tvalid in BUSY and DONE (tready is low); operands presented then are accepted in the first IDLE cycle after DONE.
REQ-024 SHALL keep the captured operand registers unchanged when tdata changes after its handshake.
REQ-025 SHALL keep sign handling outside the block; the caller pre- and post-negates for signed DIV.

Reset
REQ-026 SHALL, on reset, go to state IDLE, clear both held-flags, set the counter to 0, drive m_axis_dout_tvalid to 0 and drive both treadys to 1 in the following cycle.
REQ-027 SHALL drive m_axis_dout_tdata to 64'h0 on reset.
REQ-028 SHALL abort any BUSY or DONE operation on a mid-operation reset with no tvalid pulse; a handshake in the reset cycle is discarded.

Verification
REQ-029 SHALL cover a basic divide: both channels offer 100 and 7 in the same cycle N -> tvalid pulse in N+33 with tdata {32'd14, 32'd2}, and treadys high again in N+34.
REQ-030 SHALL cover staggered operands: dividend 0xFFFFFFFF handshakes in cycle N and divisor 1 in N+3 -> dividend tready low N+1..N+3, and tvalid in N+36 with {0xFFFFFFFF, 0}.
REQ-031 SHALL cover divide-by-zero: 0x12345678 / 0 -> tvalid after 33 cycles with {0xFFFFFFFF, 0x12345678}.
REQ-032 SHALL cover a small dividend: 5 / 9 -> {0, 5}; and 0x80000000 / 0x80000000 -> {1, 0}.
REQ-033 SHALL cover reset mid-operation: reset on BUSY iteration 10 -> no tvalid pulse ever follows, treadys high one cycle after reset, and a next 50/5 returns {10, 0} with full latency.
REQ-034 SHALL cover back-to-back operations: operands held valid continuously across two operations -> second handshake in the cycle after DONE, second tvalid exactly 34 cycles after the first, and tdata holds the first result in between.
